// File: rtl/fb_scan_reader.sv
// ----------------------------------------------------------------------------
// fb_scan_reader
//   Raster scan engine for a framebuffer held in a dual-port RAM. Owns the
//   read-only port B: issues one linear read address per enable strobe in
//   raster order, tracks the RAM read latency and returns each pixel together
//   with its x/y coordinates and a valid flag. line/frame markers accompany
//   the issued address so the VGA path can align its syncs.
//
//   Optional feature macro: DOUBLE_BUFFER_EN
//     When defined, two framebuffers are scanned alternately; a swap request
//     is applied at the next frame wrap (or restart).
//
// Ports
//   i_clk          pixel-domain clock
//   i_reset        asynchronous, active-high reset
//   i_enable       advance strobe, one read per cycle while high
//   i_restart      synchronous return to (0,0), wins over i_enable
//   o_mem_addr     RAM port-B address (registered)
//   i_mem_q        RAM port-B read data
//   o_pixel        pixel data (registered, holds when not valid)
//   o_pixel_valid  o_pixel / o_pix_x / o_pix_y valid this cycle
//   o_pix_x        column of o_pixel
//   o_pix_y        line of o_pixel
//   o_line_start   presented address has x == 0
//   o_frame_start  presented address is (0,0)
//   i_swap_req     (DOUBLE_BUFFER_EN) request a buffer swap
//   o_active_buf   (DOUBLE_BUFFER_EN) buffer currently scanned
//   o_swap_ack     (DOUBLE_BUFFER_EN) one-cycle pulse when a swap is applied
// ----------------------------------------------------------------------------
module fb_scan_reader #(
    parameter int FB_W      = 200,
    parameter int FB_H      = 200,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_restart,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_q,
    output logic [DATA_W-1:0] o_pixel,
    output logic              o_pixel_valid,
    output logic [15:0]       o_pix_x,
    output logic [15:0]       o_pix_y,
    output logic              o_line_start,
    output logic              o_frame_start
`ifdef DOUBLE_BUFFER_EN
    ,
    input  logic              i_swap_req,
    output logic              o_active_buf,
    output logic              o_swap_ack
`endif
);

    localparam int NPIX  = FB_W * FB_H;
    localparam int LIN_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [ADDR_W-1:0] BASE0 = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(BASE_ADDR + NPIX);

    // Coordinate tag travelling alongside each outstanding read.
    typedef struct packed {
        logic        vld;
        logic [15:0] x;
        logic [15:0] y;
    } tag_t;

    // ------------------------------------------------------------------
    // Issue-stage state: r_x/r_y/r_lin name the NEXT pixel to be issued.
    // ------------------------------------------------------------------
    logic [15:0]       r_x;
    logic [15:0]       r_y;
    logic [LIN_W-1:0]  r_lin;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_line_start;
    logic              r_frame_start;

    // Tag registered with the address, then RD_LAT stages covering the RAM.
    tag_t              r_iss;
    tag_t              r_pipe [RD_LAT];

    logic [DATA_W-1:0] r_pixel;
    logic              r_pixel_valid;
    logic [15:0]       r_pix_x;
    logic [15:0]       r_pix_y;

    logic              w_issue;
    logic              w_x_last;
    logic              w_y_last;
    logic              w_buf_next;
    logic [ADDR_W-1:0] w_base;
    tag_t              w_tail;

    assign w_issue  = i_enable & ~i_restart;
    assign w_x_last = (r_x == 16'(FB_W - 1));
    assign w_y_last = (r_y == 16'(FB_H - 1));
    assign w_tail   = r_pipe[RD_LAT-1];

    // ------------------------------------------------------------------
    // Buffer selection
    // ------------------------------------------------------------------
`ifdef DOUBLE_BUFFER_EN
    logic r_active_buf;
    logic r_swap_pend;
    logic r_swap_ack;
    logic w_pend;
    logic w_swap;

    // A request arriving in the wrap cycle itself is honoured at that wrap.
    assign w_pend     = r_swap_pend | i_swap_req;
    // Swap exactly when the address returns to offset 0: a restart, or an
    // issue of linear offset 0 (the first pixel after a frame wrap).
    assign w_swap     = w_pend & (i_restart | (i_enable & (r_lin == '0)));
    assign w_buf_next = r_active_buf ^ w_swap;

    always_ff @(posedge i_clk or posedge i_reset) begin : p_swap
        if (i_reset) begin
            r_active_buf <= 1'b0;
            r_swap_pend  <= 1'b0;
            r_swap_ack   <= 1'b0;
        end else begin
            r_active_buf <= w_buf_next;
            r_swap_ack   <= w_swap;
            r_swap_pend  <= w_swap ? 1'b0 : w_pend;
        end
    end

    assign o_active_buf = r_active_buf;
    assign o_swap_ack   = r_swap_ack;
`else
    assign w_buf_next = 1'b0;
`endif

    // Base uses the post-swap buffer so the switch lands with offset 0.
    assign w_base = w_buf_next ? BASE1 : BASE0;

    // ------------------------------------------------------------------
    // Address generation: linear offset is incremented alongside x/y.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin : p_issue
        if (i_reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_lin         <= '0;
            r_mem_addr    <= BASE0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (i_restart) begin
                // Present base with the markers, but this is not a tracked read.
                r_x           <= '0;
                r_y           <= '0;
                r_lin         <= '0;
                r_mem_addr    <= w_base;
                r_line_start  <= 1'b1;
                r_frame_start <= 1'b1;
            end else if (i_enable) begin
                r_mem_addr    <= w_base + ADDR_W'(r_lin);
                r_line_start  <= (r_x == '0);
                r_frame_start <= (r_lin == '0);
                if (!w_x_last) begin
                    r_x   <= r_x + 16'd1;
                    r_lin <= r_lin + LIN_W'(1);
                end else if (!w_y_last) begin
                    r_x   <= '0;
                    r_y   <= r_y + 16'd1;
                    r_lin <= r_lin + LIN_W'(1);
                end else begin
                    r_x   <= '0;
                    r_y   <= '0;
                    r_lin <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Latency pipe: tag enters with the address, shifts RD_LAT more stages
    // so that the tail lines up with the cycle q for that address is valid.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin : p_pipe
        if (i_reset) begin
            r_iss <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
        end else if (i_restart) begin
            // Drop everything in flight.
            r_iss <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_iss.vld <= w_issue;
            r_iss.x   <= r_x;
            r_iss.y   <= r_y;
            r_pipe[0] <= r_iss;
            for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Pixel output register; holds data/coords when nothing is returned.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin : p_pixel
        if (i_reset) begin
            r_pixel       <= '0;
            r_pixel_valid <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
        end else begin
            r_pixel_valid <= 1'b0;
            // A restart also drops the read returning in that same cycle.
            if (w_tail.vld && !i_restart) begin
                r_pixel       <= i_mem_q;
                r_pix_x       <= w_tail.x;
                r_pix_y       <= w_tail.y;
                r_pixel_valid <= 1'b1;
            end
        end
    end

    assign o_mem_addr    = r_mem_addr;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
    assign o_pixel       = r_pixel;
    assign o_pixel_valid = r_pixel_valid;
    assign o_pix_x       = r_pix_x;
    assign o_pix_y       = r_pix_y;

endmodule
